// File: rtl/reservation_station_pkg.sv
// reservation_station_pkg: shared tag, entry-state and ALU op definitions used by the CU and stations.
// Contents: TAG_W/TAG_NONE tag constants, ent_state_t entry encoding, ALU op codes.
package reservation_station_pkg;
   localparam int TAG_W = 4;
   localparam logic [TAG_W-1:0] TAG_NONE = 4'd0;
   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_WAITING = 2'd1,
      ST_READY   = 2'd2
   } ent_state_t;
   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;
   localparam logic [1:0] OP_AND = 2'd2;
   localparam logic [1:0] OP_OR  = 2'd3;
endpackage

// File: rtl/reservation_station_select.sv
// rs_select: picks the READY entry to dispatch (lowest index, or oldest when RS_OLDEST_FIRST_EN).
// Ports: ready (per-entry READY flags), age (2-bit issue ages, RS_OLDEST_FIRST_EN only),
//        valid (any entry READY), idx (selected entry index).
module rs_select #(
   parameter int DEPTH = 3
) (
   input  logic [DEPTH-1:0]   ready,
`ifdef RS_OLDEST_FIRST_EN
   input  logic [2*DEPTH-1:0] age,
`endif
   output logic               valid,
   output logic [1:0]         idx
);
`ifdef RS_OLDEST_FIRST_EN
   logic [1:0] best;
   logic       found;
   // Occupied entries have distinct ages, so the maximum is unique.
   always_comb begin
      best = '0;
      found = 1'b0;
      idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!found || age[2*i+:2] > best)) begin
            found = 1'b1;
            best = age[2*i+:2];
            idx = 2'(i);
         end
      end
   end
`else
   always_comb begin
      idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) if (ready[i]) idx = 2'(i);
   end
`endif
   assign valid = |ready;
endmodule

// File: rtl/reservation_station.sv
// reservation_station: Tomasulo reservation station holding DEPTH ops until operands arrive, then dispatching to the ALU.
// Ports: clk, rst (async active-high); issue_* from CU with is_full/issue_tag back; cdb_* broadcast;
//        exec_* dispatch to ALU with alu_ready handshake. Option macro: RS_OLDEST_FIRST_EN (oldest-first dispatch).
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter logic [1:0] STATION_ID = 2'd1,
   parameter int         DEPTH      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_en,
   input  logic [1:0]       issue_op,
   input  logic [31:0]      issue_vj,
   input  logic [31:0]      issue_vk,
   input  logic [TAG_W-1:0] issue_qj,
   input  logic [TAG_W-1:0] issue_qk,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_data,
   output logic             is_full,
   output logic [TAG_W-1:0] issue_tag,
   output logic             exec_valid,
   output logic [1:0]       exec_op,
   output logic [31:0]      exec_a,
   output logic [31:0]      exec_b,
   output logic [TAG_W-1:0] exec_tag,
   input  logic             alu_ready
);
   ent_state_t       state [DEPTH];
   logic [1:0]       op    [DEPTH];
   logic [31:0]      vj    [DEPTH];
   logic [31:0]      vk    [DEPTH];
   logic [TAG_W-1:0] qj    [DEPTH];
   logic [TAG_W-1:0] qk    [DEPTH];
   logic [DEPTH-1:0] ready, wj, wk;
   logic             has_free, sel_valid, do_issue, do_disp, hit_j, hit_k;
   logic [1:0]       free_idx, sel_idx;
   logic [TAG_W-1:0] nqj, nqk;
   logic [31:0]      nvj, nvk;
`ifdef RS_OLDEST_FIRST_EN
   // age = number of still-occupied entries issued after this one.
   logic [1:0]       age [DEPTH];
   logic [2*DEPTH-1:0] age_flat;
   always_comb for (int i = 0; i < DEPTH; i++) age_flat[2*i+:2] = age[i];
`endif
   always_comb begin
      has_free = 1'b0;
      free_idx = '0;
      ready = '0;
      wj = '0;
      wk = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (state[i] == ST_EMPTY) begin
            has_free = 1'b1;
            free_idx = 2'(i);
         end
         ready[i] = state[i] == ST_READY;
         // Empty entries hold q=0, and tag 0 never matches, so no occupancy gate is needed.
         wj[i] = cdb_valid && cdb_tag != TAG_NONE && qj[i] == cdb_tag;
         wk[i] = cdb_valid && cdb_tag != TAG_NONE && qk[i] == cdb_tag;
      end
   end
   // Same-cycle CDB capture for the operands being issued.
   assign hit_j = cdb_valid && cdb_tag != TAG_NONE && issue_qj == cdb_tag;
   assign hit_k = cdb_valid && cdb_tag != TAG_NONE && issue_qk == cdb_tag;
   assign nqj = hit_j ? TAG_NONE : issue_qj;
   assign nqk = hit_k ? TAG_NONE : issue_qk;
   assign nvj = hit_j ? cdb_data : issue_vj;
   assign nvk = hit_k ? cdb_data : issue_vk;
   rs_select #(.DEPTH(DEPTH)) u_sel (
      .ready(ready),
`ifdef RS_OLDEST_FIRST_EN
      .age(age_flat),
`endif
      .valid(sel_valid),
      .idx(sel_idx)
   );
   assign is_full    = !has_free;
   assign issue_tag  = has_free ? {STATION_ID, free_idx} : TAG_NONE;
   assign do_issue   = issue_en && has_free;
   assign do_disp    = sel_valid && alu_ready;
   assign exec_valid = sel_valid;
   assign exec_op    = sel_valid ? op[sel_idx] : '0;
   assign exec_a     = sel_valid ? vj[sel_idx] : '0;
   assign exec_b     = sel_valid ? vk[sel_idx] : '0;
   assign exec_tag   = sel_valid ? {STATION_ID, sel_idx} : TAG_NONE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            state[i] <= ST_EMPTY;
            op[i] <= '0;
            vj[i] <= '0;
            vk[i] <= '0;
            qj[i] <= TAG_NONE;
            qk[i] <= TAG_NONE;
`ifdef RS_OLDEST_FIRST_EN
            age[i] <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && free_idx == 2'(i)) begin
               state[i] <= (nqj == TAG_NONE && nqk == TAG_NONE) ? ST_READY : ST_WAITING;
               op[i] <= issue_op;
               vj[i] <= nvj;
               vk[i] <= nvk;
               qj[i] <= nqj;
               qk[i] <= nqk;
`ifdef RS_OLDEST_FIRST_EN
               age[i] <= '0;
`endif
            end else if (do_disp && sel_idx == 2'(i)) begin
               state[i] <= ST_EMPTY;
            end else if (state[i] != ST_EMPTY) begin
               if (wj[i]) begin
                  vj[i] <= cdb_data;
                  qj[i] <= TAG_NONE;
               end
               if (wk[i]) begin
                  vk[i] <= cdb_data;
                  qk[i] <= TAG_NONE;
               end
               if (state[i] == ST_WAITING && (wj[i] || qj[i] == TAG_NONE) && (wk[i] || qk[i] == TAG_NONE))
                  state[i] <= ST_READY;
`ifdef RS_OLDEST_FIRST_EN
               age[i] <= age[i] + 2'(do_issue) - 2'(do_disp && age[i] > age[sel_idx]);
`endif
            end
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scoreboard bench for reservation_station.
module tb_reservation_station;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        issue_en = 1'b0;
   logic [1:0]  issue_op = '0;
   logic [31:0] issue_vj = '0, issue_vk = '0;
   logic [3:0]  issue_qj = '0, issue_qk = '0;
   logic        cdb_valid = 1'b0;
   logic [3:0]  cdb_tag = '0;
   logic [31:0] cdb_data = '0;
   logic        alu_ready = 1'b0;
   logic        is_full, exec_valid;
   logic [3:0]  issue_tag, exec_tag;
   logic [1:0]  exec_op;
   logic [31:0] exec_a, exec_b;
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  tag;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;
   reservation_station #(.STATION_ID(2'd1), .DEPTH(3)) dut (
      .clk(clk), .rst(rst),
      .issue_en(issue_en), .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
      .issue_qj(issue_qj), .issue_qk(issue_qk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .is_full(is_full), .issue_tag(issue_tag),
      .exec_valid(exec_valid), .exec_op(exec_op), .exec_a(exec_a), .exec_b(exec_b), .exec_tag(exec_tag),
      .alu_ready(alu_ready)
   );
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (!rst && exec_valid && alu_ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_dispatch got op=%0d a=%h b=%h tag=%h, expected none", exec_op, exec_a, exec_b, exec_tag);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({exec_op, exec_a, exec_b, exec_tag} !== {e.op, e.a, e.b, e.tag}) begin
               errors++;
               $display("FAIL dispatch got op=%0d a=%h b=%h tag=%h, expected op=%0d a=%h b=%h tag=%h",
                        exec_op, exec_a, exec_b, exec_tag, e.op, e.a, e.b, e.tag);
            end
         end
      end
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic push(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      exp_t e;
      e.op = o;
      e.a = a;
      e.b = b;
      e.tag = t;
      q.push_back(e);
   endtask
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] j, input logic [3:0] k);
      issue_en = 1'b1;
      issue_op = o;
      issue_vj = a;
      issue_vk = b;
      issue_qj = j;
      issue_qk = k;
      tick();
      issue_en = 1'b0;
   endtask
   task automatic cdb(input logic [3:0] t, input logic [31:0] d);
      cdb_valid = 1'b1;
      cdb_tag = t;
      cdb_data = d;
      tick();
      cdb_valid = 1'b0;
   endtask
   initial begin
      #12;
      chk("reset_is_full", 32'(is_full), 32'd0);
      chk("reset_exec_valid", 32'(exec_valid), 32'd0);
      chk("reset_issue_tag", 32'(issue_tag), 32'h4);
      chk("reset_exec_tag", 32'(exec_tag), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      // Ready-on-issue: one-cycle latency, then freed.
      alu_ready = 1'b1;
      push(2'd0, 32'd5, 32'd7, 4'h4);
      issue(2'd0, 32'd5, 32'd7, 4'h0, 4'h0);
      chk("latency_exec_valid", 32'(exec_valid), 32'd1);
      chk("latency_exec_tag", 32'(exec_tag), 32'h4);
      tick();
      chk("after_dispatch_valid", 32'(exec_valid), 32'd0);
      chk("after_dispatch_issue_tag", 32'(issue_tag), 32'h4);
      // Wakeup through the CDB; tag 0 and cdb_valid=0 must not wake.
      issue(2'd1, 32'd0, 32'd3, 4'h9, 4'h0);
      chk("waiting_exec_valid", 32'(exec_valid), 32'd0);
      chk("waiting_issue_tag", 32'(issue_tag), 32'h5);
      cdb(4'h0, 32'hdead);
      chk("tag0_no_wake", 32'(exec_valid), 32'd0);
      cdb_tag = 4'h9;
      cdb_data = 32'hbad;
      tick();
      chk("cdb_invalid_no_wake", 32'(exec_valid), 32'd0);
      push(2'd1, 32'h1234, 32'd3, 4'h4);
      cdb(4'h9, 32'h1234);
      chk("wake_exec_valid", 32'(exec_valid), 32'd1);
      chk("wake_exec_a", exec_a, 32'h1234);
      tick();
      chk("wake_drained", 32'(exec_valid), 32'd0);
      // Same-cycle capture, then hold stable under back-pressure.
      alu_ready = 1'b0;
      cdb_valid = 1'b1;
      cdb_tag = 4'h5;
      cdb_data = 32'd42;
      push(2'd2, 32'd1, 32'd42, 4'h4);
      issue(2'd2, 32'd1, 32'd0, 4'h0, 4'h5);
      cdb_valid = 1'b0;
      chk("samecyc_exec_valid", 32'(exec_valid), 32'd1);
      chk("samecyc_exec_b", exec_b, 32'd42);
      tick();
      chk("stall_exec_b", exec_b, 32'd42);
      chk("stall_exec_op", 32'(exec_op), 32'd2);
      alu_ready = 1'b1;
      tick();
      alu_ready = 1'b0;
      chk("samecyc_drained", 32'(exec_valid), 32'd0);
      // Fill, overflow ignored, one dispatch frees a slot.
      for (int i = 0; i < 3; i++) begin
         chk("fill_issue_tag", 32'(issue_tag), 32'h4 + 32'(i));
         push(2'd3, 32'd10 + 32'(i), 32'd20 + 32'(i), 4'h4 + 4'(i));
         issue(2'd3, 32'd10 + 32'(i), 32'd20 + 32'(i), 4'h0, 4'h0);
      end
      chk("full_is_full", 32'(is_full), 32'd1);
      chk("full_issue_tag", 32'(issue_tag), 32'h0);
      issue(2'd0, 32'd99, 32'd99, 4'h0, 4'h0);
      chk("overflow_is_full", 32'(is_full), 32'd1);
      chk("overflow_exec_a", exec_a, 32'd10);
      alu_ready = 1'b1;
      tick();
      alu_ready = 1'b0;
      chk("freed_is_full", 32'(is_full), 32'd0);
      chk("freed_issue_tag", 32'(issue_tag), 32'h4);
      alu_ready = 1'b1;
      tick();
      tick();
      alu_ready = 1'b0;
      chk("fill_drained", 32'(exec_valid), 32'd0);
      // Entry 2 (older) becomes READY before entry 0 (younger).
      push(2'd0, 32'd1, 32'd1, 4'h4);
      issue(2'd0, 32'd1, 32'd1, 4'h0, 4'h0);
      issue(2'd2, 32'd0, 32'd0, 4'hC, 4'h0);
      issue(2'd1, 32'd0, 32'd200, 4'hB, 4'h0);
      alu_ready = 1'b1;
      tick();
      alu_ready = 1'b0;
      chk("order_reuse_tag", 32'(issue_tag), 32'h4);
      issue(2'd0, 32'd0, 32'd100, 4'hA, 4'h0);
      cdb(4'hB, 32'd22);
      chk("order_first_ready", 32'(exec_tag), 32'h6);
      cdb(4'hA, 32'd11);
`ifdef RS_OLDEST_FIRST_EN
      chk("order_selected", 32'(exec_tag), 32'h6);
      push(2'd1, 32'd22, 32'd200, 4'h6);
      push(2'd0, 32'd11, 32'd100, 4'h4);
`else
      chk("order_selected", 32'(exec_tag), 32'h4);
      push(2'd0, 32'd11, 32'd100, 4'h4);
      push(2'd1, 32'd22, 32'd200, 4'h6);
`endif
      alu_ready = 1'b1;
      tick();
      tick();
      alu_ready = 1'b0;
      chk("order_drained", 32'(exec_valid), 32'd0);
      // Mid-operation async reset discards everything.
      issue(2'd3, 32'd0, 32'd0, 4'hD, 4'h0);
      issue(2'd3, 32'd7, 32'd8, 4'h0, 4'h0);
      chk("prerst_exec_valid", 32'(exec_valid), 32'd1);
      chk("prerst_is_full", 32'(is_full), 32'd1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_exec_valid", 32'(exec_valid), 32'd0);
      chk("rst_exec_a", exec_a, 32'd0);
      chk("rst_exec_b", exec_b, 32'd0);
      chk("rst_exec_op", 32'(exec_op), 32'd0);
      chk("rst_exec_tag", 32'(exec_tag), 32'd0);
      chk("rst_is_full", 32'(is_full), 32'd0);
      chk("rst_issue_tag", 32'(issue_tag), 32'h4);
      @(posedge clk);
      #1 rst = 1'b0;
      alu_ready = 1'b1;
      cdb(4'hC, 32'd5);
      cdb(4'hD, 32'd6);
      tick();
      chk("postrst_exec_valid", 32'(exec_valid), 32'd0);
      chk("postrst_is_full", 32'(is_full), 32'd0);
      alu_ready = 1'b0;
      tick();
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
